// File: rtl/fft64_sdf_ctrl.sv
// Sequencer for a 64-point radix-2^2 SDF FFT: per-stage butterfly / -j selects,
// FIFO enables, twiddle exponents and frame-level output framing.
module fft64_sdf_ctrl #(
  parameter int TW_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sop,
  output logic       in_ready,
  output logic [5:0] s0,
  output logic [5:0] s1,
  output logic [5:0] w_en,
  output logic [5:0] r_en,
  output logic [5:0] tw_addr0,
  output logic [5:0] tw_addr1,
  output logic       out_valid,
  output logic       out_sop,
  output logic [5:0] out_idx,
  output logic       err
);

  localparam int O1 = 1;
  localparam int O3 = 3 + TW_LAT;
  localparam int O6 = 6 + 2 * TW_LAT;
  // counter value (as seen by the output registers) of the first output sample
  localparam logic [5:0] OUT_CNT0 = 6'(O6 - 2);
  localparam logic [5:0] EXIT_CNT = 6'(O6 - 3);
  localparam logic [5:0] TW0_OFF  = 6'(O1 + 1);
  localparam logic [5:0] TW1_OFF  = 6'(O3 + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic logic [5:0] stage_off(input int k);
    int o;
    o = k + ((k >= 4) ? 2 : k / 2) * TW_LAT;
    return 6'(o);
  endfunction

  function automatic logic [5:0] bitrev6(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = x[5-i];
    return r;
  endfunction

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  // hist[0]: current 64-cycle period carries a frame, hist[1]/[2]: one/two periods ago
  logic [2:0] hist, hist_nxt;
  logic [5:0] act, act_nxt;
  logic       accept, running;
  logic [5:0] np [6];
  logic [5:0] s0_nxt, s1_nxt;
  logic [5:0] m0, m1, tw0_nxt, tw1_nxt;
  logic [5:0] j_nxt, idx_nxt;
  logic       ov_nxt, sop_nxt;

  assign in_ready = (state == IDLE) || (cnt == 6'd63);
  assign accept   = in_ready & in_valid & in_sop;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 6'd1;
    hist_nxt  = hist;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        hist_nxt = '0;
        if (accept) begin
          state_nxt = RUN;
          hist_nxt  = 3'b001;
        end
      end
      RUN, FLUSH: begin
        if (cnt == 6'd63) begin
          hist_nxt  = {hist[1:0], accept};
          state_nxt = accept ? RUN : FLUSH;
        end else if (state == FLUSH && cnt == EXIT_CNT && !hist[1]) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          hist_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        hist_nxt  = '0;
      end
    endcase
  end

  // everything below is a function of the next-cycle counter so the registered
  // outputs line up with the counter value they are seen alongside
  always_comb begin
    running = (state_nxt != IDLE);
    s0_nxt  = '0;
    act_nxt = '0;
    for (int k = 0; k < 6; k++) begin
      act_nxt[k] = running & (act[k] | (cnt_nxt == stage_off(k)));
      np[k]      = cnt_nxt - stage_off(k) + 6'd1;
      s0_nxt[k]  = act_nxt[k] & np[k][5-k];
    end
    s1_nxt = {act_nxt[5] & np[5][1] & ~np[5][0], 1'b0,
              act_nxt[3] & np[3][3] & ~np[3][2], 1'b0,
              act_nxt[1] & np[1][5] & ~np[1][4], 1'b0};

    m0      = cnt_nxt - TW0_OFF;
    m1      = cnt_nxt - TW1_OFF;
    tw0_nxt = act_nxt[1] ? ({4'b0, m0[4], m0[5]} * {2'b0, m0[3:0]}) : 6'd0;
    tw1_nxt = act_nxt[3] ? ({2'b0, m1[2], m1[3], 2'b0} * {4'b0, m1[1:0]}) : 6'd0;

    ov_nxt  = running & ((cnt_nxt >= OUT_CNT0) ? hist_nxt[1] : hist_nxt[2]);
    j_nxt   = cnt_nxt - OUT_CNT0;
    idx_nxt = ov_nxt ? bitrev6(j_nxt) : 6'd0;
    sop_nxt = ov_nxt & (j_nxt == 6'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hist      <= '0;
      act       <= '0;
      s0        <= '0;
      s1        <= '0;
      w_en      <= '0;
      r_en      <= '0;
      tw_addr0  <= '0;
      tw_addr1  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_idx   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hist      <= hist_nxt;
      act       <= act_nxt;
      s0        <= s0_nxt;
      s1        <= s1_nxt;
      w_en      <= act_nxt;
      r_en      <= act_nxt;
      tw_addr0  <= tw0_nxt;
      tw_addr1  <= tw1_nxt;
      out_valid <= ov_nxt;
      out_sop   <= sop_nxt;
      out_idx   <= idx_nxt;
      // cnt==63 in RUN is the slot for the next frame's first sample, not a frame sample
      err       <= err | ((state == RUN) && (cnt != 6'd63) && !in_valid);
    end
  end

endmodule

// File: doc/fft64_sdf_ctrl.md
# fft64_sdf_ctrl

Sequencer for the 64-point radix-2² single-path delay-feedback FFT pipeline: six butterfly stages (FIFO depths 32,16,8,4,2,1; odd stages are the −j stages) plus two twiddle multipliers after stages 1 and 3. Generates per-stage butterfly select (s0), −j select (s1), FIFO enables, twiddle ROM addresses and frame-level output valid/sop/index. Accepts gapless 64-sample frames, back-to-back or separated, and drains the pipeline after the last frame.

## Interface
- TW_LAT, 2, register latency of each twiddle multiplier (cycles, 1..4)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample present this cycle
- in_sop  in  1  first sample of frame; qualified by in_valid
- in_ready  out  1  controller will accept in_sop this cycle
- s0  out  6  butterfly select, bit k for stage k
- s1  out  6  −j select; bits 0,2,4 always 0
- w_en  out  6  FIFO write enable, bit k for stage k
- r_en  out  6  FIFO read enable, bit k for stage k
- tw_addr0  out  6  twiddle exponent, multiplier after stage 1
- tw_addr1  out  6  twiddle exponent, multiplier after stage 3
- out_valid  out  1  final stage output valid
- out_sop  out  1  first output of frame
- out_idx  out  6  frequency index of current output (bit-reversed order)
- err  out  1  sticky: in_valid dropped mid-frame; cleared only by rst

## Operation
- FSM IDLE / RUN / FLUSH. IDLE: pipeline frozen (w_en=r_en=0), in_ready=1. in_sop&in_valid → RUN, cnt=0.
- RUN: 6-bit cnt increments every cycle. At cnt==63: next in_sop&in_valid → continue RUN (cnt wraps to 0); else → FLUSH.
- in_ready=1 in IDLE, in RUN/FLUSH only when cnt==63. in_sop when in_ready=0 is ignored.
- in_valid low in RUN: set err, keep counting (datapath sees whatever is on input; treated as zero-padded).
- FLUSH: cnt keeps counting, pipeline runs; after D=63+O6 cycles from the last frame's final sample → IDLE. New in_sop at cnt==63 → RUN, flush count cancelled.
- Stage input offsets: O0=0, O1=1, O2=2+TW_LAT, O3=3+TW_LAT, O4=4+2·TW_LAT, O5=5+2·TW_LAT, O6=6+2·TW_LAT.
- Sample index at stage k: n_k=(cnt−O_k) mod 64. Stage k active once a frame sample has reached it, until IDLE.
- s0[k]=n'_k[5−k]; odd k: s1[k]=n'_k[6−k]&~n'_k[5−k], where n'_k=(n_k+1) mod 64 (issued one cycle ahead; PEs register s0/s1 internally). s0/s1 forced 0 while stage inactive.
- w_en[k]=r_en[k]=stage k active (aligned to n_k, not advanced).
- Twiddle at multiplier input, index m=(cnt−O1−1) mod 64 for tw0: tw_addr0=bitrev2(m[5:4])·m[3:0] (0..45). tw1 with m=(cnt−O3−1) mod 64: tw_addr1=4·bitrev2(m[3:2])·m[1:0]. Unsigned, 6-bit result, no overflow.
- Output: frame accepted at cycle t0 (in_sop) → out_valid for cycles t0+63+O6 .. t0+126+O6; out_sop on first; out_idx=bitrev6(j), j=0..63 position within output frame.
- Up to two frames in flight (latency >64); back-to-back frames give continuous out_valid.

## Timing
- Reset values: s0,s1,w_en,r_en,tw_addr0,tw_addr1,out_idx=0; out_valid,out_sop,err=0; in_ready=1; FSM=IDLE, cnt=0.
- All outputs registered except in_ready (combinational from state and cnt).
- Latency in_sop → out_sop: 63+O6 cycles (73 at TW_LAT=2).
- rst mid-frame: all frames discarded immediately, outputs to reset values next edge-free instant (async).
- in_sop coincident with cnt==63 in FLUSH: accepted; flush ends, no gap on output.

## Test plan
- Reset then single frame (in_sop at t0, 64 valid): out_sop at t0+73, out_valid 64 cycles, out_idx 0,32,16,48,…; then IDLE, w_en=0, in_ready=1.
- Single frame, check stage 5: s0[5] toggles every cycle from cycle O5−1; s1[5]=1 when n'_5[1:0]=2'b10; s1[0,2,4]=0 throughout.
- Three back-to-back frames: in_ready high only at cnt==63; out_valid continuous 192 cycles; out_sop every 64.
- tw_addr0 sequence over one frame: m=16..31 → 2·m[3:0] (0,2,…,30); m=48..63 → 3·m[3:0]; tw_addr1 max 36.
- in_valid low at frame sample 20: err=1 and stays; frame output timing unchanged.
- rst asserted at sample 40 of frame 2: all outputs 0, in_ready=1 immediately; new frame after release gives out_sop 73 cycles later.
